// File: rtl/andg_pipe_scheduler_pkg.sv
// Shared types and helpers for the andg pipe scheduler: tag sizing,
// shadow-pipe entry layout and lane offsets into the packed operand buses.
package andg_sched_pkg;

  localparam int MAX_N     = 8;
  localparam int MAX_TAG_W = 3;

  function automatic int tag_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Tag is sized for the largest supported requester count; unused upper bits stay 0.
  typedef struct packed {
    logic                 valid;
    logic [MAX_TAG_W-1:0] tag;
  } shadow_t;

  function automatic int lane_lsb(input int k, input int w);
    return k * w;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin grant: first asserted request at or above ptr, wrapping modulo N.
module rr_arbiter
  import andg_sched_pkg::*;
#(
  parameter int N     = 3,
  parameter int TAG_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [TAG_W-1:0] ptr,
  output logic             gnt_valid,
  output logic [TAG_W-1:0] gnt
);

  always_comb begin
    int idx;
    gnt_valid = 1'b0;
    gnt       = '0;
    idx       = 0;
    for (int i = 0; i < N; i++) begin
      idx = (int'(ptr) + i) % N;
      if (!gnt_valid && req[idx]) begin
        gnt_valid = 1'b1;
        gnt       = TAG_W'(idx);
      end
    end
  end

endmodule

// File: rtl/andg_pipe_scheduler.sv
// Shares one fixed-latency andg datapath among N requesters: round-robin issue,
// tag shadow pipe aligned with the datapath, response routing and per-requester credits.
module andg_pipe_scheduler
  import andg_sched_pkg::*;
#(
  parameter int N       = 3,
  parameter int W       = 8,
  parameter int L       = 4,
  parameter int MAX_OUT = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req_valid,
  input  logic [N*W-1:0] req_a,
  input  logic [N*W-1:0] req_b,
  output logic [N-1:0]   req_ready,
  output logic           dp_valid_in,
  output logic [W-1:0]   dp_a,
  output logic [W-1:0]   dp_b,
  input  logic [W-1:0]   dp_out,
  input  logic           dp_valid_out,
  output logic [N-1:0]   rsp_valid,
  output logic [W-1:0]   rsp_data,
  output logic           idle,
  output logic           err
);

  localparam int TAG_W = tag_w(N);
  localparam int CNT_W = $clog2(MAX_OUT + 1);

  logic [TAG_W-1:0] ptr;
  logic [TAG_W-1:0] grant;
  logic             gnt_valid;
  logic             accept;
  logic [TAG_W-1:0] issue_tag;
  logic [N-1:0]     elig;
  logic [N-1:0]     inc;
  logic [N-1:0]     dec;
  logic [CNT_W-1:0] cnt [N];
  shadow_t          shadow [L];
  shadow_t          sh_out;
  logic             cnt_zero;
  logic             shadow_busy;

  assign sh_out = shadow[L-1];

  always_comb begin
    elig        = '0;
    inc         = '0;
    dec         = '0;
    cnt_zero    = 1'b1;
    shadow_busy = 1'b0;
    for (int k = 0; k < N; k++) begin
      elig[k] = req_valid[k] && (cnt[k] < CNT_W'(MAX_OUT));
      inc[k]  = accept && (grant == TAG_W'(k));
      dec[k]  = sh_out.valid && (sh_out.tag == MAX_TAG_W'(k));
      if (cnt[k] != '0) cnt_zero = 1'b0;
    end
    for (int i = 0; i < L; i++) begin
      if (shadow[i].valid) shadow_busy = 1'b1;
    end
  end

  rr_arbiter #(.N(N), .TAG_W(TAG_W)) u_arb (
    .req      (elig),
    .ptr      (ptr),
    .gnt_valid(gnt_valid),
    .gnt      (grant)
  );

  assign accept    = gnt_valid && !rst;
  assign req_ready = accept ? (N'(1) << grant) : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      dp_valid_in <= 1'b0;
      dp_a        <= '0;
      dp_b        <= '0;
      issue_tag   <= '0;
      ptr         <= '0;
    end else begin
      dp_valid_in <= accept;
      if (accept) begin
        dp_a      <= req_a[lane_lsb(32'(grant), W) +: W];
        dp_b      <= req_b[lane_lsb(32'(grant), W) +: W];
        issue_tag <= grant;
        ptr       <= (grant == TAG_W'(N - 1)) ? '0 : grant + 1'b1;
      end
    end
  end

  // Stage 0 captures the issue register, so stage L-1 lines up with dp_valid_out.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < L; i++) shadow[i] <= '0;
    end else begin
      shadow[0] <= '{valid: dp_valid_in, tag: MAX_TAG_W'(issue_tag)};
      for (int i = 1; i < L; i++) shadow[i] <= shadow[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < N; k++) cnt[k] <= '0;
    end else begin
      for (int k = 0; k < N; k++) begin
        if (inc[k] && !dec[k]) cnt[k] <= cnt[k] + 1'b1;
        else if (dec[k] && !inc[k] && cnt[k] != '0) cnt[k] <= cnt[k] - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid <= '0;
      rsp_data  <= '0;
      err       <= 1'b0;
      idle      <= 1'b1;
    end else begin
      rsp_valid <= sh_out.valid ? (N'(1) << sh_out.tag) : '0;
      if (sh_out.valid) rsp_data <= dp_out;
      if (sh_out.valid && !dp_valid_out) err <= 1'b1;
      idle <= cnt_zero && !shadow_busy && !dp_valid_in;
    end
  end

endmodule

// File: tb/tb_andg_pipe_scheduler.sv
// Bench for andg_pipe_scheduler: in-bench datapath, transaction-level reference model
// compared every cycle, directed scenarios with literal expectations, randomized traffic.
module tb_andg_pipe_scheduler;

  localparam int N       = 3;
  localparam int W       = 8;
  localparam int L       = 4;
  localparam int MAX_OUT = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_a;
  logic [N*W-1:0] req_b;
  logic [N-1:0]   req_ready;
  logic           dp_valid_in;
  logic [W-1:0]   dp_a;
  logic [W-1:0]   dp_b;
  logic [W-1:0]   dp_out;
  logic           dp_valid_out;
  logic [N-1:0]   rsp_valid;
  logic [W-1:0]   rsp_data;
  logic           idle;
  logic           err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int drop_cyc = -1;

  andg_pipe_scheduler #(.N(N), .W(W), .L(L), .MAX_OUT(MAX_OUT)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .dp_valid_in(dp_valid_in), .dp_a(dp_a), .dp_b(dp_b),
    .dp_out(dp_out), .dp_valid_out(dp_valid_out), .rsp_valid(rsp_valid),
    .rsp_data(rsp_data), .idle(idle), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Datapath: L unreset register stages then a bitwise AND; drop_cyc masks one valid.
  bit         st_v [L];
  bit [W-1:0] st_a [L];
  bit [W-1:0] st_b [L];
  always @(posedge clk) begin
    st_v[0] <= (dp_valid_in === 1'b1);
    st_a[0] <= dp_a;
    st_b[0] <= dp_b;
    for (int i = 1; i < L; i++) begin
      st_v[i] <= st_v[i-1];
      st_a[i] <= st_a[i-1];
      st_b[i] <= st_b[i-1];
    end
  end
  assign dp_valid_out = st_v[L-1] && (cyc != drop_cyc);
  assign dp_out       = st_a[L-1] & st_b[L-1];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d got %0h want %0h", name, cyc, act, exp);
    end
  endtask

  // Reference model: every accepted op is a record {accept edge t, tag, a, b}.
  // In cycle c (after edge c) an op occupies a credit while t <= c <= t+L, drives the
  // datapath input when c == t, sits at the datapath output when c == t+L and is
  // answered when c == t+L+1.
  typedef struct {
    int         t;
    int         tag;
    logic [W-1:0] a;
    logic [W-1:0] b;
  } op_t;

  op_t          ops [$];
  op_t          m_op;
  bit           armed = 1'b0;
  int           m_ptr = 0;
  int           m_cnt [N];
  int           m_gnt;
  int           m_k;
  int           m_d;
  bit           m_busy;
  bit           m_dv;
  bit           m_drop;
  bit           m_err = 1'b0;
  bit           m_idle = 1'b1;
  logic [N-1:0] m_ready;
  logic [N-1:0] m_rv;
  logic [W-1:0] m_da, m_db, m_rd;
  logic [W-1:0] m_hold_a = '0, m_hold_b = '0, m_hold_rd = '0;

  always @(negedge clk) begin
    m_busy = 1'b0; m_dv = 1'b0; m_drop = 1'b0; m_rv = '0;
    m_da = m_hold_a; m_db = m_hold_b; m_rd = m_hold_rd;
    for (int k = 0; k < N; k++) m_cnt[k] = 0;
    foreach (ops[i]) begin
      m_d = cyc - ops[i].t;
      if (m_d >= 0 && m_d <= L) begin
        m_cnt[ops[i].tag]++;
        m_busy = 1'b1;
      end
      if (m_d == 0) begin
        m_dv = 1'b1; m_da = ops[i].a; m_db = ops[i].b;
      end
      if (m_d == L && drop_cyc == cyc) m_drop = 1'b1;
      if (m_d == L + 1) begin
        m_rv[ops[i].tag] = 1'b1;
        m_rd = ops[i].a & ops[i].b;
      end
    end
    m_gnt = -1;
    m_ready = '0;
    if (!rst) begin
      for (int i = 0; i < N; i++) begin
        m_k = (m_ptr + i) % N;
        if (m_gnt < 0 && req_valid[m_k] && m_cnt[m_k] < MAX_OUT) m_gnt = m_k;
      end
    end
    if (m_gnt >= 0) m_ready[m_gnt] = 1'b1;

    if (armed) begin
      chk("req_ready", 32'(req_ready), 32'(m_ready));
      chk("dp_valid_in", 32'(dp_valid_in), 32'(m_dv));
      chk("dp_a", 32'(dp_a), 32'(m_da));
      chk("dp_b", 32'(dp_b), 32'(m_db));
      chk("rsp_valid", 32'(rsp_valid), 32'(m_rv));
      chk("rsp_data", 32'(rsp_data), 32'(m_rd));
      chk("err", 32'(err), 32'(m_err));
      chk("idle", 32'(idle), 32'(m_idle));
    end

    m_hold_a = m_da; m_hold_b = m_db; m_hold_rd = m_rd;
    if (rst) begin
      armed = 1'b1;
      ops.delete();
      m_ptr = 0;
      m_hold_a = '0; m_hold_b = '0; m_hold_rd = '0;
      m_err = 1'b0;
      m_idle = 1'b1;
    end else begin
      if (m_drop) m_err = 1'b1;
      m_idle = !m_busy;
      if (m_gnt >= 0) begin
        m_op.t   = cyc + 1;
        m_op.tag = m_gnt;
        m_op.a   = req_a[m_gnt*W +: W];
        m_op.b   = req_b[m_gnt*W +: W];
        ops.push_back(m_op);
        m_ptr = (m_gnt + 1) % N;
      end
      while (ops.size() > 0 && (cyc + 1 - ops[0].t) > L + 1) void'(ops.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_operands();
    req_a = {$urandom(), $urandom()};
    req_b = {$urandom(), $urandom()};
  endtask

  task automatic drain();
    int n;
    n = 0;
    req_valid = '0;
    while (idle !== 1'b1 && n < 60) begin
      tick();
      n++;
    end
    chk("drain_timeout", 32'(n < 60), 32'd1);
    tick();
    tick();
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic stream(input int k);
    int acc;
    acc = 0;
    req_valid = N'(1) << k;
    for (int i = 0; i < 12; i++) begin
      rand_operands();
      @(negedge clk);
      if (req_ready[k] === 1'b1) acc++;
      tick();
    end
    req_valid = '0;
    chk($sformatf("stream%0d_accepts", k), 32'(acc), 32'd4);
  endtask

  initial begin
    logic [N-1:0] seq [7];
    seq = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100, 3'b001};
    rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0;
    tick(); tick();
    rst = 1'b0;
    tick(); tick();

    // Single op from requester 1 accepted at edge 5.
    req_valid = 3'b010;
    req_a = {8'h00, 8'hF0, 8'h00};
    req_b = {8'h00, 8'h3C, 8'h00};
    @(negedge clk);
    chk("t1_ready", 32'(req_ready), 32'h2);
    tick();
    req_valid = '0;
    @(negedge clk);
    chk("t1_dp_valid_c5", 32'(dp_valid_in), 32'd1);
    chk("t1_dp_a", 32'(dp_a), 32'hF0);
    repeat (5) tick();
    @(negedge clk);
    chk("t1_rsp_valid_c10", 32'(rsp_valid), 32'h2);
    chk("t1_rsp_data_c10", 32'(rsp_data), 32'h30);
    tick(); tick();
    @(negedge clk);
    chk("t1_idle", 32'(idle), 32'd1);

    // All three requesting from reset.
    req_valid = 3'b111;
    rand_operands();
    pulse_reset();
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      chk($sformatf("rr_seq%0d", i), 32'(req_ready), 32'(seq[i]));
      rand_operands();
      tick();
    end
    repeat (10) begin
      rand_operands();
      tick();
    end

    // Reset with operations in flight.
    rst = 1'b1;
    @(negedge clk);
    chk("rst_ready_zero", 32'(req_ready), 32'd0);
    tick();
    rst = 1'b0;
    req_valid = 3'b001;
    @(negedge clk);
    chk("post_rst_idle", 32'(idle), 32'd1);
    chk("post_rst_ready", 32'(req_ready), 32'h1);
    tick();
    req_valid = '0;
    repeat (4) begin
      @(negedge clk);
      chk("post_rst_no_rsp", 32'(rsp_valid), 32'd0);
      tick();
    end
    drain();

    stream(0);
    drain();
    stream(2);
    drain();

    // Randomized traffic with occasional resets.
    repeat (1500) begin
      for (int k = 0; k < N; k++) req_valid[k] = ($urandom_range(0, 3) != 0);
      rand_operands();
      rst = ($urandom_range(0, 99) == 0);
      tick();
    end
    rst = 1'b0;
    drain();

    // Dropped datapath valid sets the sticky error.
    pulse_reset();
    req_valid = 3'b010;
    rand_operands();
    drop_cyc = cyc + 1 + L;
    tick();
    req_valid = '0;
    repeat (L + 1) tick();
    @(negedge clk);
    chk("err_set", 32'(err), 32'd1);
    repeat (5) tick();
    @(negedge clk);
    chk("err_sticky", 32'(err), 32'd1);
    drop_cyc = -1;
    pulse_reset();
    @(negedge clk);
    chk("err_cleared", 32'(err), 32'd0);
    tick(); tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog cycle %0d got timeout want finish", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
